// File: rtl/order_book_pkg.sv
// Shared sizes and record types for the bid-side order book.
// The order word layout matches slave_tdata: price in the upper half, quantity in the lower.
package order_book_pkg;

  localparam int DEPTH   = 10;
  localparam int PRICE_W = 32;
  localparam int QTY_W   = 32;

  typedef struct packed {
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   volume;
  } order_t;

  typedef struct packed {
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } level_t;

endpackage

// File: rtl/order_book_level.sv
// One book slot: its {price, qty} register plus the match/insert-before compare
// against the incoming order price.
module order_book_level #(
  parameter int PRICE_W = 32,
  parameter int QTY_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRICE_W-1:0] price_d_i,
  input  logic [QTY_W-1:0]   qty_d_i,
  input  logic [PRICE_W-1:0] ord_price_i,
  output logic [PRICE_W-1:0] price_o,
  output logic [QTY_W-1:0]   qty_o,
  output logic               hit_o,
  output logic               gt_o
);

  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0]   qty_q;
  logic               occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      price_q <= '0;
      qty_q   <= '0;
    end else begin
      price_q <= price_d_i;
      qty_q   <= qty_d_i;
    end
  end

  // An all-zero slot is empty; empty slots always accept an insertion.
  assign occ     = (price_q != '0) || (qty_q != '0);
  assign hit_o   = occ && (price_q == ord_price_i);
  assign gt_o    = !occ || (ord_price_i > price_q);
  assign price_o = price_q;
  assign qty_o   = qty_q;

endmodule

// File: rtl/order_book.sv
// Best-DEPTH bid ladder, descending price. One order per cycle: aggregate on a price
// match, otherwise insert at the first lower/empty slot and shift the tail down.
module order_book
  import order_book_pkg::*;
#(
  parameter int DEPTH   = order_book_pkg::DEPTH,
  parameter int PRICE_W = order_book_pkg::PRICE_W,
  parameter int QTY_W   = order_book_pkg::QTY_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PRICE_W+QTY_W-1:0]        slave_tdata,
  input  logic                            slave_tvalid,
  output logic [DEPTH-1:0][PRICE_W-1:0]   bidprices_out,
  output logic [DEPTH-1:0][QTY_W-1:0]     bidquantities_out
);

  function automatic logic [QTY_W-1:0] sat_add(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
    logic [QTY_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[QTY_W] ? {QTY_W{1'b1}} : s[QTY_W-1:0];
  endfunction

  order_t                         ord;
  logic                           acc;
  logic                           any_hit;
  logic [DEPTH-1:0]               hit, gt, take, shift;
  logic [DEPTH-1:0][PRICE_W-1:0]  price_q, price_d, prev_price;
  logic [DEPTH-1:0][QTY_W-1:0]    qty_q, qty_d, prev_qty;

  assign ord     = slave_tdata;
  assign acc     = slave_tvalid && (ord.price != '0) && (ord.volume != '0);
  assign any_hit = |hit;

  // prev_*[i] is slot i-1, with zero shifted into slot 0 (never selected there).
  assign prev_price = {price_q[DEPTH-2:0], {PRICE_W{1'b0}}};
  assign prev_qty   = {qty_q[DEPTH-2:0], {QTY_W{1'b0}}};

  always_comb begin
    logic seen;
    seen  = 1'b0;
    take  = '0;
    shift = '0;
    for (int i = 0; i < DEPTH; i++) begin
      take[i]  = gt[i] && !seen;
      shift[i] = seen;
      seen     = seen || gt[i];
    end
  end

  always_comb begin
    price_d = price_q;
    qty_d   = qty_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (acc) begin
        if (any_hit) begin
          if (hit[i]) qty_d[i] = sat_add(qty_q[i], ord.volume);
        end else if (take[i]) begin
          price_d[i] = ord.price;
          qty_d[i]   = ord.volume;
        end else if (shift[i]) begin
          price_d[i] = prev_price[i];
          qty_d[i]   = prev_qty[i];
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    order_book_level #(
      .PRICE_W(PRICE_W),
      .QTY_W  (QTY_W)
    ) u_level (
      .clk        (clk),
      .rst        (rst),
      .price_d_i  (price_d[g]),
      .qty_d_i    (qty_d[g]),
      .ord_price_i(ord.price),
      .price_o    (price_q[g]),
      .qty_o      (qty_q[g]),
      .hit_o      (hit[g]),
      .gt_o       (gt[g])
    );
  end

  assign bidprices_out     = price_q;
  assign bidquantities_out = qty_q;

endmodule

// File: tb/tb_order_book.sv
// Scoreboard bench for order_book: a queue-based reference book predicts the ladder
// after every edge; a monitor compares it and checks ordering on each negedge.
module tb_order_book;
  import order_book_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [63:0]                   slave_tdata;
  logic                          slave_tvalid;
  logic [DEPTH-1:0][PRICE_W-1:0] bidprices_out;
  logic [DEPTH-1:0][QTY_W-1:0]   bidquantities_out;

  order_book dut (
    .clk              (clk),
    .rst              (rst),
    .slave_tdata      (slave_tdata),
    .slave_tvalid     (slave_tvalid),
    .bidprices_out    (bidprices_out),
    .bidquantities_out(bidquantities_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DEPTH-1:0][PRICE_W-1:0] pr;
    logic [DEPTH-1:0][QTY_W-1:0]   qt;
  } snap_t;

  snap_t  sb_q[$];
  level_t book[$];
  int     n_chk  = 0;
  int     n_fail = 0;

  task automatic chk(input string name, input logic [DEPTH*PRICE_W-1:0] act,
                     input logic [DEPTH*PRICE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference book: a sorted queue, updated from the rules in plain terms.
  task automatic model_apply(input logic r, input logic v, input logic [63:0] d);
    order_t     o;
    snap_t      s;
    int         hit_idx;
    int         pos;
    logic [63:0] sum;
    o = d;
    if (r) begin
      book.delete();
    end else if (v && o.price != 0 && o.volume != 0) begin
      hit_idx = -1;
      foreach (book[j]) if (book[j].price == o.price) hit_idx = j;
      if (hit_idx >= 0) begin
        sum = 64'(book[hit_idx].qty) + 64'(o.volume);
        book[hit_idx].qty = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
      end else begin
        pos = book.size();
        for (int j = 0; j < book.size(); j++)
          if (book[j].price < o.price) begin
            pos = j;
            break;
          end
        book.insert(pos, '{price: o.price, qty: o.volume});
        if (book.size() > DEPTH) void'(book.pop_back());
      end
    end
    s.pr = '0;
    s.qt = '0;
    foreach (book[j]) begin
      s.pr[j] = book[j].price;
      s.qt[j] = book[j].qty;
    end
    sb_q.push_back(s);
  endtask

  task automatic step(input logic r, input logic v, input logic [63:0] d);
    rst          = r;
    slave_tvalid = v;
    slave_tdata  = d;
    model_apply(r, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] p, input logic [31:0] q);
    step(1'b0, 1'b1, {p, q});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, {$urandom, $urandom});
  endtask

  // Monitor: one expected snapshot per elapsed edge, plus an independent invariant check.
  initial begin
    snap_t e;
    logic  ok, empty_seen, occ;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ladder_prices", bidprices_out, e.pr);
        chk("ladder_qtys", bidquantities_out, e.qt);
        ok = 1'b1;
        empty_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          occ = (bidprices_out[i] != 0) || (bidquantities_out[i] != 0);
          if (occ && empty_seen) ok = 1'b0;
          if (!occ) empty_seen = 1'b1;
          if (occ && i > 0 && bidprices_out[i] >= bidprices_out[i-1]) ok = 1'b0;
        end
        chk("invariant", {319'b0, ok}, {319'b0, 1'b1});
      end
    end
  end

  initial begin
    rst = 1'b1;
    slave_tvalid = 1'b0;
    slave_tdata = '0;
    #1;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, {32'd999, 32'd9});
    chk("reset_prices", bidprices_out, '0);
    chk("reset_qtys", bidquantities_out, '0);

    // Basic insertion ordering
    put(32'd12304, 32'd27);
    put(32'd12702, 32'd71);
    put(32'd12000, 32'd15);
    chk("c1_l0_price", bidprices_out[0], 32'd12702);
    chk("c1_l1_price", bidprices_out[1], 32'd12304);
    chk("c1_l2_qty", bidquantities_out[2], 32'd15);
    chk("c1_l3_price", bidprices_out[3], 32'd0);

    // Aggregation and saturation
    put(32'd12304, 32'd5);
    chk("c2_l1_qty", bidquantities_out[1], 32'd32);
    put(32'd12304, 32'hFFFF_FFF6);
    chk("c2_sat_qty", bidquantities_out[1], 32'hFFFF_FFFF);

    // Zero price / zero qty ignored, idle cycles ignored
    put(32'd0, 32'd10);
    put(32'd500, 32'd0);
    repeat (3) idle();
    chk("c4_l0_price", bidprices_out[0], 32'd12702);
    chk("c4_l3_price", bidprices_out[3], 32'd0);

    // Full book: overflow drop, below-book drop, aggregate without shift
    step(1'b1, 1'b0, '0);
    for (int p = 100; p <= 110; p++) put(32'(p), 32'(p - 90));
    chk("c3_l0_price", bidprices_out[0], 32'd110);
    chk("c3_l9_price", bidprices_out[9], 32'd101);
    put(32'd50, 32'd3);
    chk("c3_l9_after50", bidprices_out[9], 32'd101);
    put(32'd105, 32'd7);
    chk("c3_l5_qty", bidquantities_out[5], 32'd22);
    chk("c3_l9_after105", bidprices_out[9], 32'd101);

    // Reset in the middle of a burst
    put(32'd200, 32'd1);
    put(32'd300, 32'd2);
    step(1'b1, 1'b1, {32'd400, 32'd3});
    chk("c5_reset_prices", bidprices_out, '0);
    put(32'd150, 32'd4);
    chk("c5_l0_price", bidprices_out[0], 32'd150);
    chk("c5_l1_price", bidprices_out[1], 32'd0);

    // Random stream against the reference book
    for (int n = 0; n < 1000; n++) begin
      logic        r, v;
      logic [31:0] p, q;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) != 0);
      p = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      q = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 100));
      step(r, v, {p, q});
    end

    slave_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 320'(sb_q.size()), 320'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/order_book.md
# order_book

Bid-side limit order book holding the best 10 price levels, sorted by descending price. It accepts one order per clock from an AXI-Stream-style slave input with no backpressure and aggregates quantity at existing price levels. It exposes the full 10-level ladder as registered parallel outputs for downstream strategy and pricing logic.

## Interface

Parameters:
- DEPTH, 10: number of bid levels kept.
- PRICE_W, 32: price width (unsigned ticks).
- QTY_W, 32: quantity width (unsigned).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- slave_tdata  input  64  order word: [63:32] = price, [31:0] = quantity.
- slave_tvalid  input  1  order valid; sampled on each rising edge.
- bidprices_out  output  [9:0][31:0]  level prices; index 0 = best (highest) bid.
- bidquantities_out  output  [9:0][31:0]  aggregated quantity per level, same indexing.

## Operation

- Internal state: DEPTH entries of {price, qty}. An entry is empty when price == 0 and qty == 0.
- Invariant:
  - Occupied entries are contiguous from index 0.
  - Occupied entries are strictly descending in price.
  - Empty entries occupy the tail.
- Each accepted order (slave_tvalid = 1 at a rising edge) with price p and quantity q is handled as follows:
  - p == 0 or q == 0: ignored; the book is unchanged.
  - p matches an occupied entry: that entry's qty becomes qty + q, saturating at 2^32-1. No reordering.
  - Otherwise, the insertion index k is the first index that is empty or holds a price < p.
    - Entries k..DEPTH-2 shift down by one.
    - Entry DEPTH-1 is discarded.
    - Entry k becomes {p, q}.
  - No k exists (book full and p below every level): order discarded.
- Implement with a single-cycle parallel compare per slot:
  - hit[i] = occupied[i] && price[i] == p.
  - gt[i] = !occupied[i] || p > price[i].
  - k = priority-encode(gt).
  - Next state of each slot: hold, take incoming order, or take slot i-1.
- There is no ready signal. Every valid cycle is consumed.
- tdata is don't-care when slave_tvalid = 0.

## Timing

- Reset: while rst = 1 at a rising edge, all entries clear to 0, so both outputs read all-zero on the following cycle. rst has priority over slave_tvalid.
- Reset mid-stream: an order presented in the reset cycle is lost. Orders are accepted from the first edge with rst = 0.
- Latency: outputs are registered directly from book state. An order accepted at edge N is visible on the outputs after edge N (one cycle).
- Throughput: one order per cycle. Back-to-back orders each see the state produced by the previous one. Consecutive same-price orders accumulate correctly.
- An order held valid for multiple cycles is applied once per cycle. This is the required behaviour; the upstream deasserts tvalid after one beat.
- No combinational path from inputs to outputs.

## Structure

- Package order_book_pkg holds:
  - DEPTH, PRICE_W, QTY_W.
  - order_t packed struct {price[31:0], volume[31:0]}, with price in the MSBs, matching the slave_tdata layout.
  - level_t struct {price, qty}.
- Optional sub-module order_book_level: one slot holding its register plus hit/gt compare. It is instantiated DEPTH times in a generate loop. The top module holds the priority encoder, next-state select, and output assignment.

## Test plan

1. Reset, then insert (12304,27), (12702,71), (12000,15), one per cycle -> levels [0..2] = 12702/71, 12304/27, 12000/15; levels 3..9 = 0/0.
2. From case 1, insert (12304,5) -> level 1 qty = 32; no other level changes. Then insert (12304, 2^32-10) -> level 1 qty saturates at 2^32-1.
3. Insert 11 distinct prices 100..110 in ascending order -> book = 110..101; 100 is dropped. Then insert 50 -> unchanged. Then insert 105 -> qty at 105 accumulates and no shift occurs.
4. Insert (0,10) and (500,0) -> book unchanged. Hold tvalid low with random tdata -> book unchanged.
5. Assert rst for one cycle during a burst of valid orders -> all outputs 0 the next cycle. The order in the reset cycle is absent; the next order becomes level 0.
6. Random stream of 1000 orders checked against a reference model -> outputs match after every cycle, and the descending/contiguity invariant holds.
